sobel_scan_ctrl: RTL and testbench
==================================

Name: sobel_scan_ctrl

Overview:
- Frame-level sequencer for the Sobel pixel pipeline.
- Accepts a raster pixel stream over a valid/ready handshake and keeps column and row counters using the team's up-counter style.
- Drives line-buffer write enables, bank select and address.
- Emits a registered window-valid strobe with centre coordinates once a full 3x3 neighbourhood exists, then reports frame completion.

Parameters:
- IMG_W_P, 640, pixels per line (>= 3)
- IMG_H_P, 480, lines per frame (>= 3)
- COL_W_P, 10, column counter width; must satisfy 2^COL_W_P >= IMG_W_P
- ROW_W_P, 9, row counter width; must satisfy 2^ROW_W_P >= IMG_H_P

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  arm a new frame (honoured in IDLE only)
- abort_i  in  1  synchronous abort, returns to IDLE
- s_valid_i  in  1  input pixel valid
- s_ready_o  out  1  input pixel ready
- lb_wr_en_o  out  1  line-buffer write strobe, equals the input beat
- lb_bank_o  out  2  line-buffer bank to write (row mod 3)
- lb_addr_o  out  COL_W_P  line-buffer column address (current col)
- m_valid_o  out  1  3x3 window valid, registered
- m_ready_i  in  1  downstream accepts window
- m_col_o  out  COL_W_P  window centre column
- m_row_o  out  ROW_W_P  window centre row
- sof_o  out  1  first window of frame, qualified by m_valid_o
- eol_o  out  1  last window of line, qualified by m_valid_o
- eof_o  out  1  last window of frame, qualified by m_valid_o
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle pulse on frame completion

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE; col=row=0; bank=0.
  - All outputs 0: m_valid_o, sof/eol/eof, done_o, busy_o, m_col_o, m_row_o.
- States: IDLE, ACTIVE, DRAIN, DONE.
- IDLE:
  - s_ready_o=0.
  - start_i=1 -> ACTIVE, counters cleared.
- ACTIVE:
  - s_ready_o = !m_valid_o | m_ready_i.
  - beat = s_valid_i & s_ready_o.
  - lb_wr_en_o=beat, lb_addr_o=col, lb_bank_o=bank.
  - On beat: col increments. At col=IMG_W_P-1, col wraps to 0, row increments and bank advances 0->1->2->0.
- Output register:
  - On beat with col>=2 and row>=2: next cycle m_valid_o=1, m_col_o=col-1, m_row_o=row-1.
  - sof_o=1 when (col,row)=(2,2).
  - eol_o=1 when col=IMG_W_P-1.
  - eof_o=1 when col=IMG_W_P-1 and row=IMG_H_P-1.
  - On beat outside that region: m_valid_o clears if it was accepted or empty.
  - m_valid_o & !m_ready_i holds all m_* outputs stable, and s_ready_o=0.
  - Latency is 1 cycle from beat to m_valid_o.
  - Output accepted with no new window -> m_valid_o=0.
- Last pixel (col=IMG_W_P-1, row=IMG_H_P-1) beat -> DRAIN.
- DRAIN:
  - s_ready_o=0.
  - Stays until the eof window handshake (m_valid_o & m_ready_i) completes, then -> DONE.
- DONE:
  - done_o=1 for exactly one cycle, then -> IDLE.
  - start_i in DONE is ignored.
- start_i in ACTIVE/DRAIN is ignored.
- abort_i (any state):
  - Next cycle state=IDLE, counters 0, m_valid_o=0, no done_o.
  - abort_i has priority over start_i and beats.
- Async reset mid-frame:
  - Immediate return to reset values; no partial windows survive.
- Counters never exceed IMG_W_P-1 / IMG_H_P-1; no saturation or overflow path exists.

Optional Feature:
- Macro: SOBEL_SCAN_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt_o (16 bits).
  - Increments each cycle in ACTIVE with s_valid_i=1 and s_ready_o=0.
  - Saturates at 16'hFFFF; clears on accepted start_i and on reset.
- Undefined: port and logic are absent; all other behaviour identical.

Test Plan:
- IMG_W_P=4, IMG_H_P=3, start, s_valid_i=1 and m_ready_i=1 held for 12 beats:
  - Exactly 2 windows, centres (1,1) and (2,1).
  - First window: sof_o=1. Second window: eol_o=1 and eof_o=1.
  - done_o pulses once, 2 cycles after the eof handshake.
  - lb_bank_o sequence over the three rows is 0,1,2.
- Same frame with m_ready_i=0 for 5 cycles on the first window:
  - m_valid_o and m_col_o=1/m_row_o=1 held stable.
  - s_ready_o=0 throughout; no beat lost; beat count still 12.
- abort_i pulsed after 6 beats:
  - Next cycle busy_o=0, m_valid_o=0, no done_o.
  - A following start_i plus 12 beats produces a correct full frame.
- rst_i asserted asynchronously mid-frame, between clock edges:
  - Outputs drop to 0 before the next edge; state IDLE.
- start_i pulsed in ACTIVE and in DONE:
  - Ignored; counters unaffected.
  - Exactly one done_o per frame.
- With SOBEL_SCAN_STALL_CNT_EN and m_ready_i=0 for 7 cycles while s_valid_i=1 and m_valid_o=1:
  - stall_cnt_o=7.
  - Resets to 0 on the next accepted start_i.

Source files
------------

// File: rtl/sobel_scan_ctrl.sv
// Frame sequencer for the Sobel pipeline: raster pixel handshake, line-buffer write control and 3x3 window strobes.
// Optional macro SOBEL_SCAN_STALL_CNT_EN adds a 16-bit upstream stall counter output (stall_cnt_o).
module sobel_scan_ctrl #(
   parameter int IMG_W_P = 640,
   parameter int IMG_H_P = 480,
   parameter int COL_W_P = 10,
   parameter int ROW_W_P = 9
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic               abort_i,
   input  logic               s_valid_i,
   output logic               s_ready_o,
   output logic               lb_wr_en_o,
   output logic [1:0]         lb_bank_o,
   output logic [COL_W_P-1:0] lb_addr_o,
   output logic               m_valid_o,
   input  logic               m_ready_i,
   output logic [COL_W_P-1:0] m_col_o,
   output logic [ROW_W_P-1:0] m_row_o,
   output logic               sof_o,
   output logic               eol_o,
   output logic               eof_o,
   output logic               busy_o,
   output logic               done_o
`ifdef SOBEL_SCAN_STALL_CNT_EN
   ,output logic [15:0]       stall_cnt_o
`endif
);

   typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, DONE} state_t;

   localparam logic [COL_W_P-1:0] COL_LAST = COL_W_P'(IMG_W_P - 1);
   localparam logic [ROW_W_P-1:0] ROW_LAST = ROW_W_P'(IMG_H_P - 1);

   state_t             state;
   logic [COL_W_P-1:0] col;
   logic [ROW_W_P-1:0] row;
   logic [1:0]         bank;
   logic               beat;
   logic               col_last;
   logic               row_last;
   logic               win_hit;
   logic               m_fire;

   // An abort blocks the input beat so no pixel is consumed in the cycle it is discarded.
   assign s_ready_o  = (state == ACTIVE) && !abort_i && (!m_valid_o || m_ready_i);
   assign beat       = s_valid_i && s_ready_o;
   assign col_last   = (col == COL_LAST);
   assign row_last   = (row == ROW_LAST);
   assign win_hit    = beat && (col >= COL_W_P'(2)) && (row >= ROW_W_P'(2));
   assign m_fire     = m_valid_o && m_ready_i;
   assign lb_wr_en_o = beat;
   assign lb_bank_o  = bank;
   assign lb_addr_o  = col;
   assign busy_o     = (state != IDLE);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= IDLE;
         col       <= '0;
         row       <= '0;
         bank      <= 2'd0;
         m_valid_o <= 1'b0;
         m_col_o   <= '0;
         m_row_o   <= '0;
         sof_o     <= 1'b0;
         eol_o     <= 1'b0;
         eof_o     <= 1'b0;
         done_o    <= 1'b0;
      end else if (abort_i) begin
         state     <= IDLE;
         col       <= '0;
         row       <= '0;
         bank      <= 2'd0;
         m_valid_o <= 1'b0;
         m_col_o   <= '0;
         m_row_o   <= '0;
         sof_o     <= 1'b0;
         eol_o     <= 1'b0;
         eof_o     <= 1'b0;
         done_o    <= 1'b0;
      end else begin
         done_o <= 1'b0;

         // A beat can only happen once the held window is gone, so a beat outside the window region empties the register.
         if (win_hit) begin
            m_valid_o <= 1'b1;
            m_col_o   <= col - COL_W_P'(1);
            m_row_o   <= row - ROW_W_P'(1);
            sof_o     <= (col == COL_W_P'(2)) && (row == ROW_W_P'(2));
            eol_o     <= col_last;
            eof_o     <= col_last && row_last;
         end else if (beat || m_fire) begin
            m_valid_o <= 1'b0;
            sof_o     <= 1'b0;
            eol_o     <= 1'b0;
            eof_o     <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (start_i) begin
                  state <= ACTIVE;
                  col   <= '0;
                  row   <= '0;
                  bank  <= 2'd0;
               end
            end
            ACTIVE: begin
               if (beat) begin
                  if (col_last) begin
                     col  <= '0;
                     bank <= (bank == 2'd2) ? 2'd0 : bank + 2'd1;
                     if (row_last) begin
                        row   <= '0;
                        state <= DRAIN;
                     end else begin
                        row <= row + ROW_W_P'(1);
                     end
                  end else begin
                     col <= col + COL_W_P'(1);
                  end
               end
            end
            DRAIN: begin
               if (m_fire) state <= DONE;
            end
            DONE: begin
               done_o <= 1'b1;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SOBEL_SCAN_STALL_CNT_EN
   // Counts cycles where upstream offers a pixel that the held output window refuses.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stall_cnt_o <= 16'h0000;
      end else if (state == IDLE && start_i && !abort_i) begin
         stall_cnt_o <= 16'h0000;
      end else if (state == ACTIVE && s_valid_i && !s_ready_o && !abort_i &&
                   stall_cnt_o != 16'hFFFF) begin
         stall_cnt_o <= stall_cnt_o + 16'h0001;
      end
   end
`endif

endmodule

// File: tb/tb_sobel_scan_ctrl.sv
// Self-checking bench for sobel_scan_ctrl on a 4x3 frame: vector table, scoreboarded frames, abort and reset corners.
// Stall counter checks run only when SOBEL_SCAN_STALL_CNT_EN is defined.
module tb_sobel_scan_ctrl;

   localparam int W  = 4;
   localparam int H  = 3;
   localparam int CW = 3;
   localparam int RW = 2;
   localparam int N  = W * H;

   logic          clk = 1'b0;
   logic          rst;
   logic          start, abort, s_valid, m_ready;
   logic          s_ready, lb_wr_en, m_valid, sof, eol, eof, busy, done;
   logic [1:0]    lb_bank;
   logic [CW-1:0] lb_addr, m_col;
   logic [RW-1:0] m_row;
`ifdef SOBEL_SCAN_STALL_CNT_EN
   logic [15:0]   stall_cnt;
`endif

   int testsRun = 0;
   int testsFailed = 0;

   typedef struct {
      logic start, sValid, mReady;
      logic sReady, wrEn;
      logic [1:0] bank;
      logic [CW-1:0] addr;
      logic mValid;
      logic [CW-1:0] mCol;
      logic [RW-1:0] mRow;
      logic sof, eol, eof, busy, done;
   } vec_t;

   typedef struct {
      logic [CW-1:0] c;
      logic [RW-1:0] r;
      logic sof, eol, eof;
   } win_t;

   vec_t vecs[17];

   always #5 clk = ~clk;

   sobel_scan_ctrl #(.IMG_W_P(W), .IMG_H_P(H), .COL_W_P(CW), .ROW_W_P(RW)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
      .s_valid_i(s_valid), .s_ready_o(s_ready),
      .lb_wr_en_o(lb_wr_en), .lb_bank_o(lb_bank), .lb_addr_o(lb_addr),
      .m_valid_o(m_valid), .m_ready_i(m_ready), .m_col_o(m_col), .m_row_o(m_row),
      .sof_o(sof), .eol_o(eol), .eof_o(eof), .busy_o(busy), .done_o(done)
`ifdef SOBEL_SCAN_STALL_CNT_EN
      , .stall_cnt_o(stall_cnt)
`endif
   );

   function automatic vec_t mkVec(input int st, sv, mr, sr, wr, bk, ad, mv, mc, mrw, so, eo, ef, bz, dn);
      vec_t v;
      v.start = 1'(st);  v.sValid = 1'(sv); v.mReady = 1'(mr);
      v.sReady = 1'(sr); v.wrEn = 1'(wr);   v.bank = 2'(bk); v.addr = CW'(ad);
      v.mValid = 1'(mv); v.mCol = CW'(mc);  v.mRow = RW'(mrw);
      v.sof = 1'(so);    v.eol = 1'(eo);    v.eof = 1'(ef);
      v.busy = 1'(bz);   v.done = 1'(dn);
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic st, input logic sv, input logic mr, input logic ab);
      start   = st;
      s_valid = sv;
      m_ready = mr;
      abort   = ab;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // mode 0: all high; 1: stall first window stallLen cycles; 2: random; 3: random with start held through DONE
   task automatic runFrame(input int mode, input int stallLen);
      win_t q[$];
      win_t w;
      int cyc = 0, beats = 0, wins = 0, doneCnt = 0, eofCyc = -1, stallLeft = -1;
      int c, r;
      logic st, sv, mr, finished;
      finished = 1'b0;
      while (!finished && cyc < 400) begin
         st = (cyc == 0) || (mode == 3 && (eofCyc < 0 || cyc <= eofCyc + 1));
         sv = 1'b1;
         mr = 1'b1;
         if (mode == 1) begin
            if (m_valid && stallLeft < 0) stallLeft = stallLen;
            mr = !(stallLeft > 0);
         end else if (mode >= 2) begin
            sv = 1'($urandom_range(0, 1));
            mr = ($urandom_range(0, 3) != 0);
         end
         applyStimulus(st, sv, mr, 1'b0);
         #4;
         checkOutput("m_valid_vs_model", 32'(m_valid), 32'(q.size() != 0));
         if (m_valid && q.size() != 0)
            checkOutput("window", 32'({m_col, m_row, sof, eol, eof}),
                        32'({q[0].c, q[0].r, q[0].sof, q[0].eol, q[0].eof}));
         checkOutput("s_ready", 32'(s_ready),
                     32'((cyc > 0 && beats < N) ? (!m_valid || m_ready) : 1'b0));
         checkOutput("busy", 32'(busy), 32'(cyc > 0 && (eofCyc < 0 || cyc <= eofCyc + 1)));
         checkOutput("lb_wr_en", 32'(lb_wr_en), 32'(s_valid && s_ready));
         if (m_valid && m_ready && q.size() != 0) begin
            w = q.pop_front();
            wins++;
            if (w.eof) eofCyc = cyc;
         end
         if (s_valid && s_ready) begin
            checkOutput("lb_bank_addr", 32'({lb_bank, lb_addr}),
                        32'({2'((beats / W) % 3), CW'(beats % W)}));
            c = beats % W;
            r = beats / W;
            if (c >= 2 && r >= 2) begin
               w.c = CW'(c - 1);
               w.r = RW'(r - 1);
               w.sof = (c == 2 && r == 2);
               w.eol = (c == W - 1);
               w.eof = (beats == N - 1);
               q.push_back(w);
            end
            beats++;
         end
         if (done) begin
            doneCnt++;
            checkOutput("done_timing", 32'(cyc), 32'(eofCyc + 2));
         end
         if (eofCyc >= 0 && cyc >= eofCyc + 4) finished = 1'b1;
         if (stallLeft > 0) stallLeft--;
         cyc++;
         nextCycle();
      end
      checkOutput("frame_timeout", 32'(finished), 32'd1);
      checkOutput("beat_count", 32'(beats), 32'(N));
      checkOutput("window_count", 32'(wins), 32'((W - 2) * (H - 2)));
      checkOutput("done_count", 32'(doneCnt), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   initial begin
      logic [17:0] act, exp;
      vec_t v;

      vecs[0] = mkVec(1,1,1, 0,0,0,0, 0,0,0,0,0,0, 0,0);
      for (int k = 0; k < 11; k++)
         vecs[k + 1] = mkVec(0,1,1, 1,1,k / W,k % W, 0,0,0,0,0,0, 1,0);
      vecs[12] = mkVec(0,1,1, 1,1,2,3, 1,1,1,1,0,0, 1,0);
      vecs[13] = mkVec(0,1,1, 0,0,0,0, 1,2,1,0,1,1, 1,0);
      vecs[14] = mkVec(0,1,1, 0,0,0,0, 0,0,0,0,0,0, 1,0);
      vecs[15] = mkVec(0,0,1, 0,0,0,0, 0,0,0,0,0,0, 0,1);
      vecs[16] = mkVec(0,0,1, 0,0,0,0, 0,0,0,0,0,0, 0,0);

      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_state", 32'({s_ready, lb_wr_en, lb_bank, lb_addr, m_valid, m_col, m_row,
                                      sof, eol, eof, busy, done}), 32'd0);
      rst = 1'b0;
      nextCycle();

      for (int i = 0; i < 17; i++) begin
         v = vecs[i];
         applyStimulus(v.start, v.sValid, v.mReady, 1'b0);
         #4;
         act = {s_ready, lb_wr_en, v.wrEn ? lb_bank : 2'd0, v.wrEn ? lb_addr : CW'(0),
                m_valid, v.mValid ? m_col : CW'(0), v.mValid ? m_row : RW'(0),
                v.mValid ? {sof, eol, eof} : 3'd0, busy, done};
         exp = {v.sReady, v.wrEn, v.bank, v.addr, v.mValid, v.mCol, v.mRow,
                v.sof, v.eol, v.eof, v.busy, v.done};
         checkOutput($sformatf("vec%0d", i), 32'(act), 32'(exp));
         nextCycle();
      end

      runFrame(1, 5);

`ifdef SOBEL_SCAN_STALL_CNT_EN
      runFrame(1, 7);
      checkOutput("stall_cnt_7", 32'(stall_cnt), 32'd7);
      runFrame(0, 0);
      checkOutput("stall_cnt_cleared", 32'(stall_cnt), 32'd0);
`endif

      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      nextCycle();
      repeat (6) begin
         applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
         nextCycle();
      end
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
      #4;
      checkOutput("abort_blocks_beat", 32'(lb_wr_en), 32'd0);
      nextCycle();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
         #4;
         checkOutput("after_abort", 32'({busy, m_valid, done, s_ready}), 32'd0);
         nextCycle();
      end
      runFrame(0, 0);

      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      nextCycle();
      repeat (11) begin
         applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
         nextCycle();
      end
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      #2;
      checkOutput("pre_reset_window", 32'(m_valid), 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("async_reset_outputs", 32'({s_ready, lb_wr_en, m_valid, m_col, m_row,
                                              sof, eol, eof, busy, done}), 32'd0);
      nextCycle();
      rst = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      #4;
      checkOutput("idle_after_reset", 32'({busy, m_valid, s_ready}), 32'd0);
      nextCycle();
      runFrame(0, 0);

      runFrame(3, 0);
      for (int f = 0; f < 8; f++) runFrame(2, 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
